// File: rtl/cmul_pkg.sv
// Shared widths, complex types and the rounding/reduction helper for cmul_pipe.
// Output saturation is selected in cmul_pipe with the CMUL_SAT_EN macro.
package cmul_pkg;

    localparam int DATA_WIDTH_DEF = 16;
    localparam int TW_WIDTH_DEF   = 16;
    localparam int OUT_WIDTH_DEF  = 16;

    localparam int PROD_W = DATA_WIDTH_DEF + TW_WIDTH_DEF;
    localparam int SUM_W  = PROD_W + 1;

    // Rounding is done in a fixed wide container so one function serves every width.
    localparam int CALC_W = 64;

    typedef struct packed {
        logic signed [DATA_WIDTH_DEF-1:0] re;
        logic signed [DATA_WIDTH_DEF-1:0] im;
    } cplx_data_t;

    typedef struct packed {
        logic signed [TW_WIDTH_DEF-1:0] re;
        logic signed [TW_WIDTH_DEF-1:0] im;
    } cplx_tw_t;

    typedef struct packed {
        logic signed [PROD_W-1:0] re;
        logic signed [PROD_W-1:0] im;
    } cplx_prod_t;

    typedef struct packed {
        logic signed [CALC_W-1:0] val;
        logic                     ovf;
    } round_t;

    // Round half up, shift right arithmetically, then clamp to out_w bits when sat is set.
    // Without sat the caller keeps the low out_w bits, which wraps.
    function automatic round_t sat_round(input logic signed [CALC_W-1:0] v,
                                         input int unsigned              shift,
                                         input int unsigned              out_w,
                                         input logic                     sat);
        round_t                   res;
        logic signed [CALC_W-1:0] r;
        logic signed [CALC_W-1:0] mx;
        logic signed [CALC_W-1:0] mn;
        r       = (v + (64'sd1 <<< (shift - 1))) >>> shift;
        mx      = (64'sd1 <<< (out_w - 1)) - 64'sd1;
        mn      = -(64'sd1 <<< (out_w - 1));
        res.val = r;
        res.ovf = 1'b0;
        if (sat) begin
            if (r > mx) begin
                res.val = mx;
                res.ovf = 1'b1;
            end else if (r < mn) begin
                res.val = mn;
                res.ovf = 1'b1;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/cmul_pipe_dly.sv
// pipe_dly: en-gated delay line of DEPTH registers, async active-high reset to 0.
// DEPTH = 0 is a straight wire.
module pipe_dly #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    generate
        if (DEPTH == 0) begin : g_bypass
            assign dout = din;
        end else begin : g_dly
            logic [WIDTH-1:0] stage_q [DEPTH];

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        stage_q[i] <= '0;
                    end
                end else if (en) begin
                    stage_q[0] <= din;
                    for (int i = 1; i < DEPTH; i++) begin
                        stage_q[i] <= stage_q[i-1];
                    end
                end
            end

            assign dout = stage_q[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/cmul_pipe.sv
// Pipelined signed complex multiplier (x twiddle or x conj(twiddle)) with rounding.
// Define CMUL_SAT_EN for saturating output and ovf_out; otherwise the output wraps.
module cmul_pipe
    import cmul_pkg::*;
#(
    parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
    parameter int TW_WIDTH    = TW_WIDTH_DEF,
    parameter int OUT_WIDTH   = OUT_WIDTH_DEF,
    parameter int SHIFT       = TW_WIDTH - 1,
    parameter int PIPE_STAGES = 3
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        en,
    input  logic                        in_valid,
    input  logic                        conj_in,
    input  logic signed [DATA_WIDTH-1:0] a_re,
    input  logic signed [DATA_WIDTH-1:0] a_im,
    input  logic signed [TW_WIDTH-1:0]   w_re,
    input  logic signed [TW_WIDTH-1:0]   w_im,
    output logic                        out_valid,
    output logic signed [OUT_WIDTH-1:0]  p_re,
    output logic signed [OUT_WIDTH-1:0]  p_im,
    output logic                        ovf_out
);

    localparam int PW = DATA_WIDTH + TW_WIDTH;
    localparam int SW = PW + 1;

`ifdef CMUL_SAT_EN
    localparam logic SAT_EN = 1'b1;
`else
    localparam logic SAT_EN = 1'b0;
`endif

    generate
        if (PIPE_STAGES < 3) begin : g_bad_stages
            $error("cmul_pipe: PIPE_STAGES must be >= 3");
        end
        if (SHIFT < 1) begin : g_bad_shift
            $error("cmul_pipe: SHIFT must be >= 1");
        end
        if (SW >= CALC_W) begin : g_bad_width
            $error("cmul_pipe: DATA_WIDTH + TW_WIDTH too wide for rounding container");
        end
    endgenerate

    typedef struct packed {
        logic signed [DATA_WIDTH-1:0] re;
        logic signed [DATA_WIDTH-1:0] im;
    } data_t;

    typedef struct packed {
        logic signed [TW_WIDTH-1:0] re;
        logic signed [TW_WIDTH-1:0] im;
    } tw_t;

    typedef struct packed {
        logic                       valid;
        logic                       ovf;
        logic signed [OUT_WIDTH-1:0] re;
        logic signed [OUT_WIDTH-1:0] im;
    } out_t;

    // Stage 1: input capture
    data_t a_q;
    tw_t   w_q;
    logic  conj1_q;
    logic  v1_q;

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            a_q     <= '0;
            w_q     <= '0;
            conj1_q <= 1'b0;
            v1_q    <= 1'b0;
        end else if (en) begin
            a_q     <= '{re: a_re, im: a_im};
            w_q     <= '{re: w_re, im: w_im};
            conj1_q <= conj_in;
            v1_q    <= in_valid;
        end
    end

    // Stage 2: four full-precision partial products
    logic signed [PW-1:0] rr_d, ii_d, ri_d, ir_d;
    logic signed [PW-1:0] rr_q, ii_q, ri_q, ir_q;
    logic                 conj2_q;
    logic                 v2_q;

    always_comb begin
        rr_d = PW'(a_q.re) * PW'(w_q.re);
        ii_d = PW'(a_q.im) * PW'(w_q.im);
        ri_d = PW'(a_q.re) * PW'(w_q.im);
        ir_d = PW'(a_q.im) * PW'(w_q.re);
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            rr_q    <= '0;
            ii_q    <= '0;
            ri_q    <= '0;
            ir_q    <= '0;
            conj2_q <= 1'b0;
            v2_q    <= 1'b0;
        end else if (en) begin
            rr_q    <= rr_d;
            ii_q    <= ii_d;
            ri_q    <= ri_d;
            ir_q    <= ir_d;
            conj2_q <= conj1_q;
            v2_q    <= v1_q;
        end
    end

    // Stage 3: sum at one extra bit, round, reduce to OUT_WIDTH
    logic signed [SW-1:0]        re_sum, im_sum;
    round_t                      re_rnd, im_rnd;
    logic signed [OUT_WIDTH-1:0] p3_re_d, p3_im_d;
    logic                        ovf3_d;
    out_t                        s3_q;

    always_comb begin
        if (conj2_q) begin
            re_sum = SW'(rr_q) + SW'(ii_q);
            im_sum = SW'(ir_q) - SW'(ri_q);
        end else begin
            re_sum = SW'(rr_q) - SW'(ii_q);
            im_sum = SW'(ir_q) + SW'(ri_q);
        end
        re_rnd  = sat_round(CALC_W'(re_sum), SHIFT, OUT_WIDTH, SAT_EN);
        im_rnd  = sat_round(CALC_W'(im_sum), SHIFT, OUT_WIDTH, SAT_EN);
        p3_re_d = re_rnd.val[OUT_WIDTH-1:0];
        p3_im_d = im_rnd.val[OUT_WIDTH-1:0];
`ifdef CMUL_SAT_EN
        ovf3_d  = re_rnd.ovf | im_rnd.ovf;
`else
        ovf3_d  = 1'b0;
`endif
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            s3_q <= '0;
        end else if (en) begin
            s3_q <= '{valid: v2_q, ovf: ovf3_d, re: p3_re_d, im: p3_im_d};
        end
    end

    // Extra latency beyond three stages is added after the result register.
    out_t out_s;

    pipe_dly #(
        .WIDTH ($bits(out_t)),
        .DEPTH (PIPE_STAGES - 3)
    ) u_out_dly (
        .clk  (clk),
        .rst  (rst_n),
        .en   (en),
        .din  (s3_q),
        .dout (out_s)
    );

    assign out_valid = out_s.valid;
    assign p_re      = out_s.re;
    assign p_im      = out_s.im;
`ifdef CMUL_SAT_EN
    assign ovf_out   = out_s.ovf;
`else
    assign ovf_out   = 1'b0;
`endif

endmodule

// File: doc/cmul_pipe.md
Name: cmul_pipe

Overview:
- Parametrised, pipelined signed complex multiplier for the FFT butterfly twiddle path; successor to the single-register real multiplier.
- Computes data x twiddle, or data x conj(twiddle) for IFFT, per sample.
- Rounds and rescales the full-precision result to OUT_WIDTH and carries a valid bit through a stallable pipeline.
- Sits between the butterfly adder stage and the next-stage reorder buffer.

Parameters:
- DATA_WIDTH, 16: width of each real/imag data input, two's complement.
- TW_WIDTH, 16: width of each twiddle component, signed Q1.(TW_WIDTH-1).
- OUT_WIDTH, 16: width of each output component.
- SHIFT, TW_WIDTH-1: right shift applied after the sum, before rounding truncation; must be >= 1.
- PIPE_STAGES, 3: total latency in cycles; must be >= 3. Stages beyond 3 are appended as output delay registers.

Ports:
- clk, input, 1: clock, rising edge.
- rst_n, input, 1: asynchronous, active-high reset (asserted = 1).
- en, input, 1: pipeline advance; 0 freezes every register, including the valid bits.
- in_valid, input, 1: input sample qualifier.
- conj_in, input, 1: 1 = multiply by conjugate twiddle; travels with the sample.
- a_re, a_im, input, DATA_WIDTH each: data sample.
- w_re, w_im, input, TW_WIDTH each: twiddle factor.
- out_valid, output, 1: output sample qualifier.
- p_re, p_im, output, OUT_WIDTH each: scaled product.
- ovf_out, output, 1: saturation occurred on p_re or p_im of the current output sample.

Behaviour:
- Reset (async, rst_n=1): all pipeline data registers, valid bits, p_re, p_im, out_valid and ovf_out go to 0 immediately. Reset mid-stream discards every in-flight sample; there is no output until new in_valid samples arrive after release.
- All registers load only when en=1. With en=0, outputs hold their last value and out_valid holds, so a held valid sample is not repeated as new data to the consumer.
- Stage 1: register a, w, conj_in and in_valid.
- Stage 2: register four full products, each DATA_WIDTH+TW_WIDTH bits signed: rr=a_re*w_re, ii=a_im*w_im, ri=a_re*w_im, ir=a_im*w_re.
- Stage 3, normal (conj=0): re = rr - ii, im = ir + ri.
- Stage 3, conjugate (conj=1): re = rr + ii, im = ir - ri.
- Sums are computed at DATA_WIDTH+TW_WIDTH+1 bits so no intermediate overflow occurs.
- Rounding is round-half-up: add 2^(SHIFT-1), then arithmetic shift right by SHIFT.
- The result is reduced to OUT_WIDTH as described in Optional Feature, and the result and valid bit are registered.
- Latency: exactly PIPE_STAGES enabled cycles from in_valid sampled to out_valid.
- Throughput: 1 sample per enabled cycle; back-to-back in_valid is fully supported.
- Data registers load regardless of in_valid. Only valid bits qualify data; consumers must ignore p_* while out_valid=0.
- conj_in is sampled with its own data and never affects neighbouring samples.
- Elaboration check: PIPE_STAGES < 3 or SHIFT < 1 raises $error.

Optional Feature:
- Macro: CMUL_SAT_EN.
- Defined: a shifted value above 2^(OUT_WIDTH-1)-1 clamps to that maximum, and a value below -2^(OUT_WIDTH-1) clamps to that minimum. ovf_out=1 for that sample, registered alongside the data.
- Undefined: MSBs are dropped, giving two's-complement wrap. ovf_out is tied to 0.

Decomposition:
- Package cmul_pkg: localparams PROD_W = DATA_WIDTH+TW_WIDTH and SUM_W = PROD_W+1.
- cmul_pkg also holds the typedef struct cplx_t {re, im} for the data, twiddle and product widths, and a function sat_round(), used for rounding and reduction.
- One sub-module, pipe_dly: parametrised width and depth, en-gated delay line with async active-high reset to 0. It implements the extra PIPE_STAGES-3 output stages and is bypassed when depth is 0.

Test Plan:
- Basic multiply: a=(16384,0), w=(16384,0), conj=0, en=1 -> after 3 cycles out_valid=1, p=(8192,0), ovf_out=0.
- Conjugate: a=(0,16384), w=(0,16384). With conj=0 -> p=(-8192,0); with conj=1 -> p=(8192,0).
- Rounding: a=(1,0), w=(16384,0) -> p_re=1. a=(-1,0), same w -> p_re=0.
- Overflow: a=(-32768,-32768), w=(-32768,0).
  - With CMUL_SAT_EN: p=(32767,32767), ovf_out=1.
  - Without CMUL_SAT_EN: p=(-32768,-32768), ovf_out=0.
- Stall: stream 4 back-to-back samples, drop en for 2 cycles mid-stream -> outputs and out_valid frozen during the stall, all 4 results appear in order, none duplicated or lost.
- Reset and latency:
  - Assert rst_n=1 mid-stream with 2 samples in flight -> p=0 and out_valid=0 immediately, with no late outputs after release.
  - Repeat with PIPE_STAGES=5 -> latency is exactly 5 cycles.
